zap_cp15_responder: RTL
=======================

# zap_cp15_responder

Coprocessor-side responder for the core's low-bandwidth coprocessor interface. It accepts the 32-bit instruction word and valid that the predecode stage issues while stalling the pipeline, executes CP15 MRC/MCR against a 16-entry CP15 register bank, and moves data through a single register-file port into the CPU. It returns a one-cycle done pulse that releases the predecode stall. It sits beside the core, with its register port muxed into the CPU register file while the pipeline is frozen.

## Interface
- PHY_REGS, 46, number of physical CPU registers; the register address width is $clog2(PHY_REGS).
- CP_ID, 32'h4107_0000, read-only value of CP15 c0.
- CTRL_RESET, 32'h0000_0000, reset value of CP15 c1.

- i_clk  in  1  core clock.
- i_reset_n  in  1  reset. One clock; reset is asynchronous and active-low.
- i_cp_dav  in  1  coprocessor request valid. Held high until after o_cp_done.
- i_cp_word  in  32  full coprocessor instruction. Stable while i_cp_dav is high.
- i_cpsr_mode  in  5  current CPU mode. Sampled with the request and used for translation.
- o_cp_done  out  1  one-cycle completion pulse.
- o_reg_en  out  1  register port access strobe.
- o_reg_wr  out  1  1 means write, 0 means read. Meaningful only when o_reg_en is high.
- o_reg_addr  out  $clog2(PHY_REGS)  physical index, equal to translate(Rd, latched mode). Uses the shared translate function.
- o_reg_wr_data  out  32  write data.
- i_reg_rd_data  in  32  read data. Valid the cycle after a read strobe.
- o_ctrl  out  32  current CP15 c1 value. Drives MMU and cache enables.

## Operation
- Decode of the latched word:
  - MRC when [27:24]=1110, [4]=1, [20]=1.
  - MCR when [27:24]=1110, [4]=1, [20]=0.
  - CDP when [27:24]=1110, [4]=0.
  - LDC/STC when [27:25]=110.
  - CRn=[19:16], Rd=[15:12].
- Coprocessor number, mode and thumb filtering are done upstream. The word is not re-checked.
- Register bank: 16 x 32.
  - c0 reads CP_ID; writes to c0 are ignored.
  - c1 resets to CTRL_RESET.
  - All other entries reset to 0.
- FSM states and transitions:
  - IDLE: when i_cp_dav=1, latch the word and i_cpsr_mode, then go to:
    - MCR_RD for MCR.
    - MRC_WR for MRC.
    - ACK for CDP, LDC, STC, or any other word. These complete as no-ops.
  - MCR_RD: o_reg_en=1, o_reg_wr=0, o_reg_addr=translate(Rd). Next state MCR_CAP.
  - MCR_CAP: bank[CRn] <= i_reg_rd_data, unless CRn=0. Next state ACK.
  - MRC_WR: o_reg_en=1, o_reg_wr=1, o_reg_wr_data=bank[CRn] (CP_ID if CRn=0). Next state ACK.
    - If Rd=15, o_reg_en stays 0 and no write occurs.
  - ACK: o_cp_done=1. Next state HOLD.
  - HOLD: stay until i_cp_dav=0, then go to IDLE.
- HOLD is required because the initiator may be frozen by a data or issue stall. In that case i_cp_dav stays high after done, and the request must never be re-executed.
- Deassertion of i_cp_dav in any non-IDLE state (pipeline clear) has these effects:
  - The FSM completes its current state sequence.
  - A pending write still occurs. Its register-file effect is discarded by the flush upstream.
  - The done pulse still fires.
  - The FSM then returns to IDLE through HOLD.

## Timing
- All outputs are decoded from registered state and latched fields. There is no combinational input-to-output path.
- Latency counts from the first cycle i_cp_dav is high in IDLE (cycle 0) to o_cp_done:
  - MCR: read strobe in cycle 1, capture in cycle 2, done in cycle 3.
  - MRC: write strobe in cycle 1, done in cycle 2.
  - Others: done in cycle 1.
- o_cp_done is high for exactly one cycle per accepted request.
- After done, the earliest new acceptance is the cycle after i_cp_dav is observed low.
- Reset values while i_reset_n=0:
  - state IDLE.
  - o_cp_done=0, o_reg_en=0, o_reg_wr=0, o_reg_addr=0, o_reg_wr_data=0.
  - o_ctrl=CTRL_RESET.
  - Bank entries other than c1 are 0.
- Reset asserted mid-operation aborts immediately. No bank update occurs and no done pulse is issued.
- o_ctrl updates in the cycle after MCR_CAP.

## Test plan
- Reset: hold i_reset_n=0 for 3 cycles -> all outputs at reset values, o_ctrl=CTRL_RESET; no o_cp_done after release.
- MCR: i_cp_word=32'hEE01_3F10 (c1 <- R3), mode SVC; on the read strobe, return i_reg_rd_data=32'h0000_1005 -> read strobe in cycle 1 with addr=translate(3,SVC), done in cycle 3, o_ctrl=32'h0000_1005.
- MRC: after the MCR case, send 32'hEE11_5F10 (R5 <- c1) -> cycle 1 write strobe, addr=translate(5,SVC), data 32'h0000_1005, done in cycle 2.
- c0 protection: MCR to c0 with data 32'hDEAD_BEEF, then MRC from c0 to R2 -> written data equals CP_ID.
- CDP plus stall: send 32'hEE00_0F00 and hold i_cp_dav high 5 cycles after done -> single done in cycle 1, no o_reg_en, no second done; drop dav, then issue MRC -> accepted normally.
- Abort: assert reset during MCR_CAP -> o_ctrl unchanged, no o_cp_done, FSM in IDLE after release.

Source files
------------

// File: rtl/zap_cp15_responder_if.sv
// Coprocessor request / register-port bundle between the core and the
// CP15 responder. The master side is the core (predecode + register file),
// the slave side is the responder.
interface zap_cp15_responder_if #(
    parameter int PHY_REGS = 46
);
    localparam int AW = $clog2(PHY_REGS);

    // Request from predecode, held while the pipeline is stalled.
    logic          i_cp_dav;
    logic [31:0]   i_cp_word;
    logic [4:0]    i_cpsr_mode;

    // Completion pulse that releases the stall.
    logic          o_cp_done;

    // Single register-file port, muxed into the CPU register file.
    logic          o_reg_en;
    logic          o_reg_wr;
    logic [AW-1:0] o_reg_addr;
    logic [31:0]   o_reg_wr_data;
    logic [31:0]   i_reg_rd_data;

    // Live CP15 c1 (MMU / cache enables).
    logic [31:0]   o_ctrl;

    modport slave (
        input  i_cp_dav, i_cp_word, i_cpsr_mode, i_reg_rd_data,
        output o_cp_done, o_reg_en, o_reg_wr, o_reg_addr, o_reg_wr_data, o_ctrl
    );

    modport master (
        output i_cp_dav, i_cp_word, i_cpsr_mode, i_reg_rd_data,
        input  o_cp_done, o_reg_en, o_reg_wr, o_reg_addr, o_reg_wr_data, o_ctrl
    );
endinterface

// File: rtl/zap_cp15_responder.sv
// CP15 responder: executes MRC/MCR against a 16 x 32 CP15 bank and moves
// data through one CPU register-file port. CDP, LDC/STC and anything else
// complete as no-ops. Every output is a flop; nothing combinational reaches
// an output from an input.
module zap_cp15_responder #(
    parameter int          PHY_REGS   = 46,
    parameter logic [31:0] CP_ID      = 32'h4107_0000,
    parameter logic [31:0] CTRL_RESET = 32'h0000_0000
) (
    input  logic                i_clk,
    input  logic                i_reset_n,
    zap_cp15_responder_if.slave cp
);
    localparam int AW = $clog2(PHY_REGS);

    // CPSR mode encodings that own banked registers.
    localparam logic [4:0] M_FIQ = 5'h11;
    localparam logic [4:0] M_IRQ = 5'h12;
    localparam logic [4:0] M_SVC = 5'h13;
    localparam logic [4:0] M_ABT = 5'h17;
    localparam logic [4:0] M_UND = 5'h1B;

    typedef enum logic [2:0] {
        S_IDLE,
        S_MCR_RD,
        S_MCR_CAP,
        S_MRC_WR,
        S_ACK,
        S_HOLD
    } state_t;

    // Architectural -> physical register map.
    //   0..15  : user/system view (15 is the PC, never banked)
    //   16..22 : FIQ r8..r14
    //   23,24  : IRQ r13,r14
    //   25,26  : SVC r13,r14
    //   27,28  : ABT r13,r14
    //   29,30  : UND r13,r14
    // Unknown modes fall back to the user view.
    function automatic logic [AW-1:0] translate(input logic [3:0] rd, input logic [4:0] mode);
        int idx;
        idx = int'(rd);
        case (mode)
            M_FIQ:   if (rd >= 4'd8  && rd != 4'd15) idx = 16 + int'(rd) - 8;
            M_IRQ:   if (rd == 4'd13 || rd == 4'd14) idx = 23 + int'(rd) - 13;
            M_SVC:   if (rd == 4'd13 || rd == 4'd14) idx = 25 + int'(rd) - 13;
            M_ABT:   if (rd == 4'd13 || rd == 4'd14) idx = 27 + int'(rd) - 13;
            M_UND:   if (rd == 4'd13 || rd == 4'd14) idx = 29 + int'(rd) - 13;
            default: ;
        endcase
        return AW'(idx);
    endfunction

    state_t        state;
    logic [3:0]    crn_q;       // CRn of the accepted word, needed at capture
    logic [31:0]   bank [16];   // entry 0 is never written; c0 reads CP_ID
    logic          done_q;
    logic          reg_en_q;
    logic          reg_wr_q;
    logic [AW-1:0] reg_addr_q;
    logic [31:0]   reg_wr_data_q;

    // Field decode of the incoming word. CDP, LDC/STC and unknown words need
    // no separate decode: anything that is not MRC/MCR goes straight to ACK.
    logic       is_cdt;
    logic       is_mrc;
    logic       is_mcr;
    logic [3:0] crn_in;
    logic [3:0] rd_in;
    logic [31:0] bank_rd;

    // Combinational decode of the request and the CP15 read mux.
    always_comb begin
        is_cdt  = (cp.i_cp_word[27:24] == 4'b1110) && cp.i_cp_word[4];
        is_mrc  = is_cdt &&  cp.i_cp_word[20];
        is_mcr  = is_cdt && !cp.i_cp_word[20];
        crn_in  = cp.i_cp_word[19:16];
        rd_in   = cp.i_cp_word[15:12];
        bank_rd = (crn_in == 4'd0) ? CP_ID : bank[crn_in];
    end

    // Request FSM, CP15 bank and registered register-port outputs.
    // The translated address is computed once at acceptance from the word
    // and mode present then, so it stays tied to the latched request even if
    // the mode input moves while the request is in flight.
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            state         <= S_IDLE;
            crn_q         <= 4'd0;
            done_q        <= 1'b0;
            reg_en_q      <= 1'b0;
            reg_wr_q      <= 1'b0;
            reg_addr_q    <= '0;
            reg_wr_data_q <= 32'h0;
            for (int i = 0; i < 16; i++) begin
                bank[i] <= (i == 1) ? CTRL_RESET : 32'h0;
            end
        end else begin
            // Strobe and done are single-cycle unless re-armed below.
            done_q   <= 1'b0;
            reg_en_q <= 1'b0;

            case (state)
                S_IDLE: begin
                    if (cp.i_cp_dav) begin
                        crn_q      <= crn_in;
                        reg_addr_q <= translate(rd_in, cp.i_cpsr_mode);
                        if (is_mcr) begin
                            reg_en_q <= 1'b1;
                            reg_wr_q <= 1'b0;
                            state    <= S_MCR_RD;
                        end else if (is_mrc) begin
                            // A PC destination suppresses the write entirely.
                            reg_en_q      <= (rd_in != 4'd15);
                            reg_wr_q      <= 1'b1;
                            reg_wr_data_q <= bank_rd;
                            state         <= S_MRC_WR;
                        end else begin
                            done_q <= 1'b1;
                            state  <= S_ACK;
                        end
                    end
                end

                // Read data arrives the cycle after the strobe.
                S_MCR_RD: state <= S_MCR_CAP;

                S_MCR_CAP: begin
                    if (crn_q != 4'd0) begin
                        bank[crn_q] <= cp.i_reg_rd_data;
                    end
                    done_q <= 1'b1;
                    state  <= S_ACK;
                end

                S_MRC_WR: begin
                    done_q <= 1'b1;
                    state  <= S_ACK;
                end

                S_ACK: state <= S_HOLD;

                // A frozen initiator keeps dav high after done; wait it out so
                // the same request is never executed twice.
                S_HOLD: if (!cp.i_cp_dav) state <= S_IDLE;

                default: state <= S_IDLE;
            endcase
        end
    end

    assign cp.o_cp_done     = done_q;
    assign cp.o_reg_en      = reg_en_q;
    assign cp.o_reg_wr      = reg_wr_q;
    assign cp.o_reg_addr    = reg_addr_q;
    assign cp.o_reg_wr_data = reg_wr_data_q;
    assign cp.o_ctrl        = bank[1];
endmodule
